// File: rtl/component_decode_sequencer_pkg.sv
// Shared types and constants for the component decode sequencer.
// State encodings, AC coefficients per 8x8 block, and the AC scan length helper.
package component_decode_sequencer_pkg;

   typedef enum logic [2:0] {
      SEQ_IDLE  = 3'd0,
      SEQ_DC    = 3'd1,
      SEQ_AC    = 3'd2,
      SEQ_DRAIN = 3'd3,
      SEQ_DONE  = 3'd4
   } seq_state_e;

   localparam int unsigned AC_PER_BLOCK     = 63;
   localparam int unsigned DEF_MAX_BLOCKS   = 32;
   localparam int unsigned DEF_IDCT_LATENCY = 10;

   function automatic logic [31:0] ac_total(input logic [31:0] blocks);
      return blocks * 32'(AC_PER_BLOCK);
   endfunction

endpackage

// File: rtl/component_decode_position_counter.sv
// AC scan position register with next-position adder and overrun/complete compares.
// Total scan length is captured once when a component is accepted.
module component_decode_position_counter
   import component_decode_sequencer_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        clear_i,
   input  logic [31:0] block_num_i,
   input  logic        advance_i,
   input  logic [5:0]  run_i,
   output logic [31:0] pos_o,
   output logic        overrun_o,
   output logic        complete_o
);

   logic [31:0] pos_q, pos_d;
   logic [31:0] total_q;
   logic [31:0] next_pos;

   assign next_pos   = pos_q + {26'd0, run_i} + 32'd1;
   assign overrun_o  = next_pos > total_q;
   assign complete_o = next_pos == total_q;
   assign pos_o      = pos_q;

   // Position only moves on a pair that stays strictly inside the scan.
   always_comb begin
      pos_d = pos_q;
      if (clear_i) begin
         pos_d = '0;
      end else if (advance_i && (next_pos < total_q)) begin
         pos_d = next_pos;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pos_q   <= '0;
         total_q <= '0;
      end else begin
         pos_q <= pos_d;
         if (clear_i) begin
            total_q <= ac_total(block_num_i);
         end
      end
   end

endmodule

// File: rtl/component_decode_sequencer.sv
// Sequences DC VLD, AC VLD, then IDCT drain for one slice component.
// Advances on VLD valid strobes; all outputs are registered.
module component_decode_sequencer
   import component_decode_sequencer_pkg::*;
#(
   parameter int unsigned MAX_BLOCKS   = DEF_MAX_BLOCKS,
   parameter int unsigned IDCT_LATENCY = DEF_IDCT_LATENCY
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] block_num,
   output logic        dc_vld_enable,
   input  logic        dc_vld_valid,
   output logic [31:0] dc_vld_counter,
   output logic        ac_vld_enable,
   input  logic        ac_vld_valid,
   input  logic [5:0]  ac_vld_run,
   output logic [31:0] ac_vld_counter,
   input  logic        slice_end,
   output logic        idct_start,
   output logic        busy,
   output logic        done,
   output logic        error
);

   seq_state_e  state_q;
   logic [31:0] blocks_q;
   logic [31:0] dc_cnt_q;
   logic [31:0] drain_q;
   logic        dc_en_q, ac_en_q, idct_q, busy_q, done_q, error_q;
   logic        accept, ac_step, overrun, complete;

   assign accept  = (state_q == SEQ_IDLE) && start;
   assign ac_step = (state_q == SEQ_AC) && ac_vld_valid;

   component_decode_position_counter u_pos (
      .clock       (clock),
      .reset_n     (reset_n),
      .clear_i     (accept),
      .block_num_i (block_num),
      .advance_i   (ac_step),
      .run_i       (ac_vld_run),
      .pos_o       (ac_vld_counter),
      .overrun_o   (overrun),
      .complete_o  (complete)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= SEQ_IDLE;
         blocks_q <= '0;
         dc_cnt_q <= '0;
         drain_q  <= '0;
         dc_en_q  <= 1'b0;
         ac_en_q  <= 1'b0;
         idct_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         idct_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            SEQ_IDLE: begin
               if (start) begin
                  blocks_q <= block_num;
                  dc_cnt_q <= '0;
                  error_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  if (block_num == 32'd0) begin
                     state_q <= SEQ_DONE;
                     done_q  <= 1'b1;
                  end else if (block_num > 32'(MAX_BLOCKS)) begin
                     error_q <= 1'b1;
                     state_q <= SEQ_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= SEQ_DC;
                     dc_en_q <= 1'b1;
                  end
               end
            end
            SEQ_DC: begin
               if (dc_vld_valid) begin
                  if (dc_cnt_q == blocks_q - 32'd1) begin
                     state_q <= SEQ_AC;
                     dc_en_q <= 1'b0;
                     ac_en_q <= 1'b1;
                  end else begin
                     dc_cnt_q <= dc_cnt_q + 32'd1;
                  end
               end
            end
            SEQ_AC: begin
               // A pair arriving with slice_end is still checked for overrun first.
               if (ac_vld_valid && overrun) begin
                  error_q <= 1'b1;
                  ac_en_q <= 1'b0;
                  state_q <= SEQ_DONE;
                  done_q  <= 1'b1;
               end else if ((ac_vld_valid && complete) || slice_end) begin
                  ac_en_q <= 1'b0;
                  idct_q  <= 1'b1;
                  drain_q <= 32'(IDCT_LATENCY) + blocks_q - 32'd1;
                  state_q <= SEQ_DRAIN;
               end
            end
            SEQ_DRAIN: begin
               if (drain_q == 32'd0) begin
                  state_q <= SEQ_DONE;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= drain_q - 32'd1;
               end
            end
            SEQ_DONE: begin
               state_q <= SEQ_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= SEQ_IDLE;
               busy_q  <= 1'b0;
               dc_en_q <= 1'b0;
               ac_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign dc_vld_enable  = dc_en_q;
   assign dc_vld_counter = dc_cnt_q;
   assign ac_vld_enable  = ac_en_q;
   assign idct_start     = idct_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;

endmodule
